decrypter_pipe: RTL and testbench

- Parametrised, handshaked, iterative decryption engine. Each input frame carries the payload, key and selector.
- Top bits of the selector pick one of four decrypt modes. The mode runs for ROUNDS clock cycles, one round per cycle.
- Sits between the frame receiver and the plaintext sink, replacing the free-running select-and-register decrypter.
- Adds valid/ready flow control, multi-round operation, busy status and a completed-block counter.

---
 rtl/decrypter_pipe.sv | 148 ++++++++++++++
 tb/tb_decrypter_pipe.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decrypter_pipe.sv
// decrypter_pipe: handshaked, iterative decryption engine.
// A frame {payload, key, sel} is accepted in IDLE, run for ROUNDS single-cycle
// rounds in one of four modes, then held in DONE until the sink takes it.
module decrypter_pipe #(
    parameter int unsigned DATA_W = 60,
    parameter int unsigned KEY_W  = 12,
    parameter int unsigned SEL_W  = 6,
    parameter int unsigned ROUNDS = 4
) (
    input  logic                            Clk,
    input  logic                            Rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_W+KEY_W+SEL_W-1:0]   data_to_be_decrypt,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_W-1:0]               output_decrypted,
    output logic [1:0]                      out_mode,
    output logic                            busy,
    output logic [15:0]                     blk_count
);

    localparam int unsigned FRAME_W = DATA_W + KEY_W + SEL_W;
    localparam int unsigned CNT_W   = $clog2(ROUNDS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   d_q;
    logic [DATA_W-1:0]   rk_q;
    logic [1:0]          mode_q;
    logic [CNT_W-1:0]    rnd_q;

    logic [DATA_W-1:0]   frm_payload;
    logic [KEY_W-1:0]    frm_key;
    logic [1:0]          frm_mode;
    logic [DATA_W-1:0]   round_d;

    // Frame fields: payload at the MSBs, selector at the LSBs; mode is the selector's top two bits.
    assign frm_payload = data_to_be_decrypt[FRAME_W-1 -: DATA_W];
    assign frm_key     = data_to_be_decrypt[SEL_W +: KEY_W];
    assign frm_mode    = data_to_be_decrypt[SEL_W-1 -: 2];

    // Key replicated from bit 0 upward, truncated to DATA_W bits.
    function automatic logic [DATA_W-1:0] expand_key(input logic [KEY_W-1:0] k);
        logic [DATA_W-1:0] e;
        e = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            e[i] = k[i % KEY_W];
        end
        return e;
    endfunction

    // Rotate left by one within DATA_W.
    function automatic logic [DATA_W-1:0] rotl1(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] y;
        y = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            y[i] = x[(i + DATA_W - 1) % DATA_W];
        end
        return y;
    endfunction

    // Rotate right by one within DATA_W.
    function automatic logic [DATA_W-1:0] rotr1(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] y;
        y = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            y[i] = x[(i + 1) % DATA_W];
        end
        return y;
    endfunction

    // One decrypt round on the working register with the current round key.
    always_comb begin
        round_d = d_q;
        case (mode_q)
            2'd0:    round_d = d_q ^ rk_q;
            2'd1:    round_d = rotr1(d_q) ^ rk_q;
            2'd2:    round_d = d_q - rk_q;
            default: round_d = ~(d_q ^ rk_q);
        endcase
    end

    // Control FSM, datapath registers and registered status outputs.
    // The round key register starts at K and rotates left once per round, so in
    // round r it holds K rotated left by (r mod DATA_W) without a barrel shifter.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state            <= IDLE;
            d_q              <= '0;
            rk_q             <= '0;
            mode_q           <= 2'd0;
            rnd_q            <= '0;
            output_decrypted <= '0;
            out_mode         <= 2'd0;
            out_valid        <= 1'b0;
            in_ready         <= 1'b1;
            busy             <= 1'b0;
            blk_count        <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        d_q      <= frm_payload;
                        rk_q     <= expand_key(frm_key);
                        mode_q   <= frm_mode;
                        rnd_q    <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    d_q   <= round_d;
                    rk_q  <= rotl1(rk_q);
                    rnd_q <= rnd_q + CNT_W'(1);
                    if (rnd_q == CNT_W'(ROUNDS - 1)) begin
                        state            <= DONE;
                        out_valid        <= 1'b1;
                        output_decrypted <= round_d;
                        out_mode         <= mode_q;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        blk_count <= blk_count + 16'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decrypter_pipe.sv
// Bench for decrypter_pipe: one instance with ROUNDS=1 and one with ROUNDS=4,
// directed frames with a scoreboard of expected plaintext per instance.
module tb_decrypter_pipe;

    localparam int unsigned DW = 60;
    localparam int unsigned KW = 12;
    localparam int unsigned SW = 6;
    localparam int unsigned FW = DW + KW + SW;

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    mode;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          in_valid_a  [2];
    logic          in_ready_a  [2];
    logic [FW-1:0] frame_a     [2];
    logic          out_valid_a [2];
    logic          out_ready_a [2];
    logic [DW-1:0] out_data_a  [2];
    logic [1:0]    out_mode_a  [2];
    logic          busy_a      [2];
    logic [15:0]   blk_a       [2];

    int   total = 0;
    int   bad   = 0;
    int   rounds_of [2];
    int   blk_exp   [2];
    exp_t sb0 [$];
    exp_t sb1 [$];

    decrypter_pipe #(.DATA_W(DW), .KEY_W(KW), .SEL_W(SW), .ROUNDS(1)) u_r1 (
        .Clk(clk), .Rst(rst),
        .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
        .data_to_be_decrypt(frame_a[0]),
        .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]),
        .output_decrypted(out_data_a[0]), .out_mode(out_mode_a[0]),
        .busy(busy_a[0]), .blk_count(blk_a[0])
    );

    decrypter_pipe #(.DATA_W(DW), .KEY_W(KW), .SEL_W(SW), .ROUNDS(4)) u_r4 (
        .Clk(clk), .Rst(rst),
        .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
        .data_to_be_decrypt(frame_a[1]),
        .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]),
        .output_decrypted(out_data_a[1]), .out_mode(out_mode_a[1]),
        .busy(busy_a[1]), .blk_count(blk_a[1])
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference decrypt: expanded key, explicit rotate by (r mod DW) each round.
    function automatic logic [DW-1:0] model(input logic [DW-1:0] p, input logic [KW-1:0] k,
                                            input logic [SW-1:0] s, input int rounds);
        logic [DW-1:0] kx;
        logic [DW-1:0] rk;
        logic [DW-1:0] d;
        int sh;
        kx = '0;
        rk = '0;
        for (int i = 0; i < int'(DW); i++) kx[i] = k[i % int'(KW)];
        d = p;
        for (int r = 0; r < rounds; r++) begin
            sh = r % int'(DW);
            for (int i = 0; i < int'(DW); i++) rk[(i + sh) % int'(DW)] = kx[i];
            case (s[SW-1 -: 2])
                2'd0:    d = d ^ rk;
                2'd1:    d = {d[0], d[DW-1:1]} ^ rk;
                2'd2:    d = d - rk;
                default: d = ~(d ^ rk);
            endcase
        end
        return d;
    endfunction

    task automatic push_exp(input int idx, input logic [DW-1:0] ed, input logic [1:0] em);
        exp_t e;
        e.data = ed;
        e.mode = em;
        if (idx == 0) sb0.push_back(e);
        else          sb1.push_back(e);
    endtask

    task automatic pop_exp(input int idx, input string tag, output exp_t e);
        e.data = '0;
        e.mode = 2'd0;
        if (idx == 0) begin
            check({tag, "_sb_nonempty"}, 64'(sb0.size() != 0), 64'(1));
            if (sb0.size() != 0) e = sb0.pop_front();
        end else begin
            check({tag, "_sb_nonempty"}, 64'(sb1.size() != 0), 64'(1));
            if (sb1.size() != 0) e = sb1.pop_front();
        end
    endtask

    // Wait for in_ready, present the frame for one edge, record the expectation.
    task automatic send(input int idx, input string tag, input logic [DW-1:0] p,
                        input logic [KW-1:0] k, input logic [SW-1:0] s,
                        input logic [DW-1:0] ed);
        int n;
        n = 0;
        while (in_ready_a[idx] !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_in_ready"}, 64'(in_ready_a[idx]), 64'(1));
        frame_a[idx]    = {p, k, s};
        in_valid_a[idx] = 1'b1;
        push_exp(idx, ed, s[SW-1 -: 2]);
        tick();
        in_valid_a[idx] = 1'b0;
    endtask

    // Called just after the accept edge: wait for out_valid, check latency, busy, data and completion.
    task automatic collect(input int idx, input string tag);
        int   n;
        exp_t e;
        n = 0;
        while (out_valid_a[idx] !== 1'b1 && n < 40) begin
            check({tag, "_busy_run"}, 64'(busy_a[idx]), 64'(1));
            tick();
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(rounds_of[idx]));
        check({tag, "_busy_done"}, 64'(busy_a[idx]), 64'(1));
        pop_exp(idx, tag, e);
        check({tag, "_data"}, 64'(out_data_a[idx]), 64'(e.data));
        check({tag, "_mode"}, 64'(out_mode_a[idx]), 64'(e.mode));
        out_ready_a[idx] = 1'b1;
        tick();
        blk_exp[idx] = (blk_exp[idx] + 1) & 16'hFFFF;
        check({tag, "_valid_drop"}, 64'(out_valid_a[idx]), 64'(0));
        check({tag, "_ready_back"}, 64'(in_ready_a[idx]), 64'(1));
        check({tag, "_blk"}, 64'(blk_a[idx]), 64'(blk_exp[idx]));
    endtask

    initial begin
        exp_t          e;
        int            n;
        logic [DW-1:0] pa;
        logic [KW-1:0] ka;
        logic [SW-1:0] sa;

        rounds_of[0] = 1;
        rounds_of[1] = 4;
        for (int i = 0; i < 2; i++) begin
            in_valid_a[i]  = 1'b0;
            out_ready_a[i] = 1'b1;
            frame_a[i]     = '0;
            blk_exp[i]     = 0;
        end

        // Reset state.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            check("rst_in_ready", 64'(in_ready_a[i]), 64'(1));
            check("rst_busy", 64'(busy_a[i]), 64'(0));
            check("rst_out_valid", 64'(out_valid_a[i]), 64'(0));
            check("rst_data", 64'(out_data_a[i]), 64'(0));
            check("rst_mode", 64'(out_mode_a[i]), 64'(0));
            check("rst_blk", 64'(blk_a[i]), 64'(0));
        end

        // ROUNDS=1 directed vectors with hand-derived results.
        send(0, "m0_key", 60'h0, 12'hABC, 6'h05, 60'hABCABCABCABCABC);
        collect(0, "m0_key");
        send(0, "m2_sub", 60'h0, 12'h001, 6'h20, 60'hFFEFFEFFEFFEFFF);
        collect(0, "m2_sub");
        send(0, "m1_rot", 60'h000000000000001, 12'h000, 6'h10, 60'h800000000000000);
        collect(0, "m1_rot");

        // ROUNDS=4: mode 3 with zero key inverts an even number of times.
        send(1, "m3_cnt", 60'h123456789ABCDEF, 12'h000, 6'h30, 60'h123456789ABCDEF);
        collect(1, "m3_cnt");

        // ROUNDS=4: all modes with non-trivial keys, back to back.
        send(1, "r4_m0", 60'h0F1E2D3C4B5A697, 12'h5A3, 6'h0A, model(60'h0F1E2D3C4B5A697, 12'h5A3, 6'h0A, 4));
        collect(1, "r4_m0");
        send(1, "r4_m1", 60'hFEDCBA987654321, 12'h3C1, 6'h17, model(60'hFEDCBA987654321, 12'h3C1, 6'h17, 4));
        collect(1, "r4_m1");
        send(1, "r4_m2", 60'h000000000000003, 12'hFFF, 6'h2B, model(60'h000000000000003, 12'hFFF, 6'h2B, 4));
        collect(1, "r4_m2");
        send(1, "r4_m3", 60'hA5A5A5A5A5A5A5A, 12'h801, 6'h3F, model(60'hA5A5A5A5A5A5A5A, 12'h801, 6'h3F, 4));
        collect(1, "r4_m3");

        // Backpressure: hold the sink off for 10 cycles with a stray in_valid pulse.
        pa = 60'h13579BDF2468ACE;
        ka = 12'h7E5;
        sa = 6'h29;
        out_ready_a[1] = 1'b0;
        send(1, "bp", pa, ka, sa, model(pa, ka, sa, 4));
        n = 0;
        while (out_valid_a[1] !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("bp_latency", 64'(n), 64'(4));
        pop_exp(1, "bp", e);
        check("bp_data", 64'(out_data_a[1]), 64'(e.data));
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin
                frame_a[1]    = {60'hDEADBEEF0000001, 12'h111, 6'h00};
                in_valid_a[1] = 1'b1;
            end else begin
                in_valid_a[1] = 1'b0;
            end
            tick();
            check("bp_hold_valid", 64'(out_valid_a[1]), 64'(1));
            check("bp_hold_data", 64'(out_data_a[1]), 64'(e.data));
            check("bp_hold_mode", 64'(out_mode_a[1]), 64'(e.mode));
            check("bp_hold_in_ready", 64'(in_ready_a[1]), 64'(0));
            check("bp_hold_blk", 64'(blk_a[1]), 64'(blk_exp[1]));
        end
        in_valid_a[1]  = 1'b0;
        out_ready_a[1] = 1'b1;
        tick();
        blk_exp[1] = (blk_exp[1] + 1) & 16'hFFFF;
        check("bp_release_valid", 64'(out_valid_a[1]), 64'(0));
        check("bp_release_in_ready", 64'(in_ready_a[1]), 64'(1));
        check("bp_release_blk", 64'(blk_a[1]), 64'(blk_exp[1]));
        for (int c = 0; c < 6; c++) begin
            tick();
            check("bp_stray_not_captured", 64'(out_valid_a[1] | busy_a[1]), 64'(0));
        end

        // Reset two cycles after accept: the block is aborted.
        send(1, "abort", 60'h0123456789ABCDE, 12'h246, 6'h33, model(60'h0123456789ABCDE, 12'h246, 6'h33, 4));
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb1.delete();
        blk_exp[0] = 0;
        blk_exp[1] = 0;
        check("abort_valid", 64'(out_valid_a[1]), 64'(0));
        check("abort_data", 64'(out_data_a[1]), 64'(0));
        check("abort_blk", 64'(blk_a[1]), 64'(0));
        check("abort_in_ready", 64'(in_ready_a[1]), 64'(1));
        for (int c = 0; c < 8; c++) begin
            tick();
            check("abort_no_output", 64'(out_valid_a[1]), 64'(0));
        end

        // Engine still works after the abort.
        send(1, "post_abort", 60'h0000FFFF0000FFF, 12'h0F0, 6'h1C, model(60'h0000FFFF0000FFF, 12'h0F0, 6'h1C, 4));
        collect(1, "post_abort");

        check("sb0_drained", 64'(sb0.size()), 64'(0));
        check("sb1_drained", 64'(sb1.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
